mc_ctrl: RTL
============

Name: mc_ctrl

Overview:
- Multicycle control sequencer for the RV32I core.
- Consumes the ID stage's decoded fields (opcode, f3, f7) plus status from the comparator and the memory port.
- Drives the enables that step the shared datapath: instruction register, PC, register-file write (WrEn), memory request and the ALU/mux selects.
- Counts retired instructions, traps on illegal opcodes and on memory-handshake timeouts.

Parameters:
- MEM_TIMEOUT, 16, max cycles mem_req may stay high without mem_ready before a bus trap (must be ≥1).
- CNT_W, 32, width of the instret counter.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  7  decoded opcode from ID.
- f3  in  3  decoded funct3 (unused internally, forwarded for ALU decode).
- f7  in  7  decoded funct7 (unused internally).
- rd_zero  in  1  destination register is x0.
- branch_taken  in  1  comparator result, valid in EXEC.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write (store).
- addr_sel  out  1  0=PC, 1=ALU result.
- ir_en  out  1  load instruction register.
- pc_en  out  1  update PC.
- pc_sel  out  2  00 PC+4, 01 PC+imm, 10 {ALU[31:1],1'b0}.
- WrEn  out  1  register-file write enable.
- wb_sel  out  2  00 ALU, 01 memory data, 10 PC+4.
- alu_op  out  2  00 ADD, 01 BRANCH-compare, 10 FUNCT (f3/f7), 11 PASS_B.
- alu_b_imm  out  1  ALU operand B = immediate.
- trap  out  1  sticky trap flag.
- trap_cause  out  2  00 none, 01 illegal opcode, 10 bus timeout.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (async):
  - State goes to FETCH; all outputs are 0 except those FETCH drives combinationally.
  - mem_req is 0 during reset. trap, trap_cause, instret and the timeout counter are cleared.
  - Reset mid-request abandons the request. The first cycle after release is a fresh FETCH.
- States:
  - FETCH:
    - mem_req=1, addr_sel=0.
    - On mem_ready: ir_en=1 (combinational with mem_ready), go to DECODE. Otherwise stay.
  - DECODE:
    - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.
    - Any other opcode → TRAP with cause 01. Otherwise → EXEC. No enables asserted.
  - EXEC:
    - alu_b_imm=1 for all except R-type and BRANCH.
    - alu_op: R/I-ALU=10, LUI=11, BRANCH=01, others=00.
    - BRANCH: pc_en=1, pc_sel=01 if branch_taken else 00; retire; → FETCH.
    - LOAD/STORE → MEM.
    - All others → WB.
  - MEM:
    - mem_req=1, addr_sel=1, mem_we=1 for STORE.
    - On mem_ready: STORE sets pc_en=1, pc_sel=00, retires and → FETCH; LOAD → WB. Otherwise stay.
  - WB:
    - WrEn = !rd_zero for one cycle.
    - wb_sel: LOAD=01, JAL/JALR=10, else 00.
    - pc_en=1; pc_sel: JAL=01, JALR=10, else 00.
    - Retire; → FETCH.
  - TRAP: every enable and mem_req is 0; trap=1; remain until rst.
- Timeout:
  - The counter increments each cycle mem_req=1 && !mem_ready, and clears on mem_ready or on state change.
  - Reaching MEM_TIMEOUT → TRAP with cause 10.
  - If mem_ready arrives in the same cycle the limit would be hit, mem_ready wins and there is no trap.
- Opcode capture: opcode is registered in DECODE. Later states use the latched copy, so ID changes after DECODE have no effect.
- instret:
  - +1 in each retiring cycle. Wraps modulo 2^CNT_W.
  - Never increments on a trapping instruction.
- Latency with mem_ready tied high:
  - R/I/LUI/AUIPC/JAL/JALR: 4 cycles.
  - BRANCH: 3 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
- At most one of ir_en, pc_en, WrEn per cycle, except WB which asserts pc_en and WrEn together.

Decomposition:
- Shared package core_pkg:
  - Opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC).
  - State enum, and the alu_op, pc_sel, wb_sel and trap_cause enums.
- One sub-module, mc_timeout: a counter with clear/inc inputs and an expired output, parameterised by MEM_TIMEOUT.

Test Plan:
1. ADD x18,x9,x8 (0x00848933), mem_ready=1 → ir_en cycle 0; WrEn=1, wb_sel=00, pc_en=1, pc_sel=00 in cycle 3; instret 0→1.
2. SW (0x0182a223), mem_ready low for 3 MEM cycles then high → mem_we=1 held 4 cycles, WrEn never 1, retire on ready cycle; BEQ with branch_taken=1 → pc_sel=01 in cycle 2.
3. LW to x0 (rd_zero=1) → 5 cycles, WrEn stays 0, pc_en=1 in WB, instret increments; JALR → pc_sel=10, wb_sel=10.
4. Opcode 0x7F in DECODE → trap=1, trap_cause=01 next cycle; mem_req stays 0 for 20 further cycles; instret unchanged.
5. MEM_TIMEOUT=4, mem_ready held 0 in FETCH → trap_cause=10 after 4 cycles; repeat with mem_ready=1 exactly at limit → no trap, proceeds to DECODE.
6. Assert rst mid-MEM (mem_req=1) → mem_req drops same timestep, trap/instret clear; after release FETCH with addr_sel=0; instret wrap with CNT_W=3: 8 retirements → 0.

Source files
------------

// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg : shared definitions for the multicycle RV32I control path.
//   - RV32I major opcodes consumed by the sequencer
//   - FSM state enum and the encoded select/cause enums driven on mc_ctrl ports
//   - is_legal_opcode() helper used by DECODE
// -----------------------------------------------------------------------------
package core_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_TRAP
   } state_e;

   typedef enum logic [1:0] {
      ALU_ADD    = 2'b00,
      ALU_BRANCH = 2'b01,
      ALU_FUNCT  = 2'b10,
      ALU_PASS_B = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      PC_PLUS4 = 2'b00,
      PC_IMM   = 2'b01,
      PC_ALU   = 2'b10
   } pc_sel_e;

   typedef enum logic [1:0] {
      WB_ALU = 2'b00,
      WB_MEM = 2'b01,
      WB_PC4 = 2'b10
   } wb_sel_e;

   typedef enum logic [1:0] {
      TRAP_NONE    = 2'b00,
      TRAP_ILLEGAL = 2'b01,
      TRAP_BUS     = 2'b10
   } trap_cause_e;

   function automatic logic is_legal_opcode(input logic [6:0] op);
      case (op)
         OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
         OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
         default:                           return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mc_timeout.sv
// -----------------------------------------------------------------------------
// mc_timeout : memory-handshake watchdog.
//   Counts consecutive cycles with a pending, unanswered request. o_expired
//   fires in the cycle that would be the MEM_TIMEOUT-th unanswered one, so the
//   owner can leave the waiting state on the following edge.
// Ports:
//   clk       core clock
//   rst       async active-high reset
//   i_clr     restart the count (request answered or owner changed state)
//   i_inc     request pending and not answered this cycle
//   o_expired limit reached this cycle
// -----------------------------------------------------------------------------
module mc_timeout #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_inc,
   output logic o_expired
);

   localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT - 1);

   logic [CW-1:0] r_cnt;

   // Depends only on i_inc and the count, never on i_clr, so the owner may
   // derive i_clr from a next-state that itself consumes o_expired.
   assign o_expired = i_inc && (r_cnt == LIMIT);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != LIMIT)) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/mc_ctrl.sv
// -----------------------------------------------------------------------------
// mc_ctrl : multicycle control sequencer for the RV32I core.
//   FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH, with a terminal TRAP
//   state for illegal opcodes and memory-handshake timeouts.
// Ports:
//   clk, rst            core clock / async active-high reset
//   opcode, f3, f7      decoded fields from ID (f3/f7 consumed by ALU decode)
//   rd_zero             destination is x0 (suppresses WrEn)
//   branch_taken        comparator result, sampled in EXEC
//   mem_ready           memory completes the current request
//   mem_req, mem_we     memory request / store
//   addr_sel            memory address: 0 PC, 1 ALU result
//   ir_en, pc_en        instruction-register load / PC update
//   pc_sel, wb_sel      next-PC and write-back source selects
//   WrEn                register-file write enable
//   alu_op, alu_b_imm   ALU operation / operand-B immediate select
//   trap, trap_cause    sticky trap flag and its cause
//   instret             retired-instruction counter (wraps)
// -----------------------------------------------------------------------------
module mc_ctrl
   import core_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       opcode,
   input  logic [2:0]       f3,
   input  logic [6:0]       f7,
   input  logic             rd_zero,
   input  logic             branch_taken,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             addr_sel,
   output logic             ir_en,
   output logic             pc_en,
   output logic [1:0]       pc_sel,
   output logic             WrEn,
   output logic [1:0]       wb_sel,
   output logic [1:0]       alu_op,
   output logic             alu_b_imm,
   output logic             trap,
   output logic [1:0]       trap_cause,
   output logic [CNT_W-1:0] instret
);

   state_e           r_state;
   logic [6:0]       r_opcode;
   trap_cause_e      r_trap_cause;
   logic [CNT_W-1:0] r_instret;

   state_e           w_next_state;
   logic             w_mem_req;
   logic             w_retire;
   logic             w_expired;
   logic             w_mem_phase;
   alu_op_e          w_alu_op;
   pc_sel_e          w_pc_sel;
   wb_sel_e          w_wb_sel;
   trap_cause_e      w_trap_cause_nxt;

   // f3/f7 are forwarded to ALU decode outside this block.
   logic w_unused;
   assign w_unused = ^{f3, f7};

   // Kept separate from the FSM process so the watchdog path has no
   // dependency on next-state logic.
   assign w_mem_phase = (r_state == S_FETCH) || (r_state == S_MEM);

   mc_timeout #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_timeout (
      .clk       (clk),
      .rst       (rst),
      .i_clr     (mem_ready || (w_next_state != r_state)),
      .i_inc     (w_mem_phase && !mem_ready),
      .o_expired (w_expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_FETCH;
         r_opcode     <= '0;
         r_trap_cause <= TRAP_NONE;
         r_instret    <= '0;
      end else begin
         r_state <= w_next_state;
         if (r_state == S_DECODE) begin
            r_opcode <= opcode;
         end
         if ((r_state != S_TRAP) && (w_next_state == S_TRAP)) begin
            r_trap_cause <= w_trap_cause_nxt;
         end
         if (w_retire) begin
            r_instret <= r_instret + CNT_W'(1);
         end
      end
   end

   // NOTE: every signal gets a default before the case so no path leaves a
   // value unassigned, which would otherwise infer a latch.
   always_comb begin
      w_next_state     = r_state;
      w_trap_cause_nxt = TRAP_NONE;
      w_mem_req        = 1'b0;
      w_retire         = 1'b0;
      mem_we           = 1'b0;
      addr_sel         = 1'b0;
      ir_en            = 1'b0;
      pc_en            = 1'b0;
      WrEn             = 1'b0;
      alu_b_imm        = 1'b0;
      w_alu_op         = ALU_ADD;
      w_pc_sel         = PC_PLUS4;
      w_wb_sel         = WB_ALU;

      case (r_state)
         S_FETCH: begin
            w_mem_req = 1'b1;
            if (w_expired) begin
               w_next_state     = S_TRAP;
               w_trap_cause_nxt = TRAP_BUS;
            end else if (mem_ready) begin
               ir_en        = 1'b1;
               w_next_state = S_DECODE;
            end
         end

         S_DECODE: begin
            if (is_legal_opcode(opcode)) begin
               w_next_state = S_EXEC;
            end else begin
               w_next_state     = S_TRAP;
               w_trap_cause_nxt = TRAP_ILLEGAL;
            end
         end

         S_EXEC: begin
            alu_b_imm = !((r_opcode == OP_R) || (r_opcode == OP_BRANCH));
            case (r_opcode)
               OP_R, OP_IMM: w_alu_op = ALU_FUNCT;
               OP_LUI:       w_alu_op = ALU_PASS_B;
               OP_BRANCH:    w_alu_op = ALU_BRANCH;
               default:      w_alu_op = ALU_ADD;
            endcase
            if (r_opcode == OP_BRANCH) begin
               pc_en        = 1'b1;
               w_pc_sel     = branch_taken ? PC_IMM : PC_PLUS4;
               w_retire     = 1'b1;
               w_next_state = S_FETCH;
            end else if ((r_opcode == OP_LOAD) || (r_opcode == OP_STORE)) begin
               w_next_state = S_MEM;
            end else begin
               w_next_state = S_WB;
            end
         end

         S_MEM: begin
            w_mem_req = 1'b1;
            addr_sel  = 1'b1;
            mem_we    = (r_opcode == OP_STORE);
            if (w_expired) begin
               w_next_state     = S_TRAP;
               w_trap_cause_nxt = TRAP_BUS;
            end else if (mem_ready) begin
               if (r_opcode == OP_STORE) begin
                  pc_en        = 1'b1;
                  w_retire     = 1'b1;
                  w_next_state = S_FETCH;
               end else begin
                  w_next_state = S_WB;
               end
            end
         end

         S_WB: begin
            WrEn  = !rd_zero;
            pc_en = 1'b1;
            case (r_opcode)
               OP_LOAD:          w_wb_sel = WB_MEM;
               OP_JAL, OP_JALR:  w_wb_sel = WB_PC4;
               default:          w_wb_sel = WB_ALU;
            endcase
            case (r_opcode)
               OP_JAL:   w_pc_sel = PC_IMM;
               OP_JALR:  w_pc_sel = PC_ALU;
               default:  w_pc_sel = PC_PLUS4;
            endcase
            w_retire     = 1'b1;
            w_next_state = S_FETCH;
         end

         S_TRAP: begin
            w_next_state = S_TRAP;
         end

         default: begin
            w_next_state = S_FETCH;
         end
      endcase
   end

   // The state register resets straight into FETCH; masking with rst keeps
   // the bus quiet for as long as reset is held.
   assign mem_req    = w_mem_req && !rst;
   assign alu_op     = w_alu_op;
   assign pc_sel     = w_pc_sel;
   assign wb_sel     = w_wb_sel;
   assign trap       = (r_state == S_TRAP);
   assign trap_cause = r_trap_cause;
   assign instret    = r_instret;

endmodule
